// File: rtl/gun_pkg.sv
// Shared types for the light-gun position block: speed states, position type,
// joystick direction bit indices and small conversion helpers.
package gun_pkg;

  typedef enum logic [2:0] {
    SPD_IDLE = 3'd0,
    SPD_S1   = 3'd1,
    SPD_S2   = 3'd2,
    SPD_S3   = 3'd3,
    SPD_S4   = 3'd4
  } speed_e;

  typedef logic [5:0] pos_t;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  function automatic speed_e speedNext(speed_e s);
    case (s)
      SPD_IDLE: return SPD_S1;
      SPD_S1:   return SPD_S2;
      SPD_S2:   return SPD_S3;
      default:  return SPD_S4;
    endcase
  endfunction

  // (a + 128) >> 2 is the offset-binary value (sign bit inverted) dropped by two bits
  function automatic pos_t analogToPos(logic [7:0] a, int maxPos);
    pos_t raw;
    raw = {~a[7], a[6:2]};
    if (int'(raw) > maxPos) return pos_t'(maxPos);
    return raw;
  endfunction

endpackage

// File: rtl/gun_if.sv
// Joystick/video inputs and gun position outputs of the gun position block.
interface gun_if
  import gun_pkg::*;
;
  logic       video_vblank;
  logic [3:0] joy_dir;
  logic [7:0] joy_ax;
  logic [7:0] joy_ay;
  logic       analog_mode;
  logic       recenter;
  pos_t       gun_h;
  pos_t       gun_v;
  logic       frame_tick;

  modport master (
    output video_vblank, joy_dir, joy_ax, joy_ay, analog_mode, recenter,
    input  gun_h, gun_v, frame_tick
  );

  modport slave (
    input  video_vblank, joy_dir, joy_ax, joy_ay, analog_mode, recenter,
    output gun_h, gun_v, frame_tick
  );
endinterface

// File: rtl/gun_axis.sv
// One gun axis: holds the position register and applies a saturating step
// (plus/minus cancel each other) or a direct load.
module gun_axis
  import gun_pkg::*;
#(
  parameter int MAX_POS = 63,
  parameter int CENTER  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] step,
  input  logic       plus,
  input  logic       minus,
  input  logic       load,
  input  pos_t       load_value,
  output pos_t       pos
);

  localparam logic signed [8:0] MAX_S    = 9'(MAX_POS);
  localparam pos_t              CENTER_P = pos_t'(CENTER);

  pos_t              pos_q;
  pos_t              pos_d;
  logic signed [8:0] posExt;
  logic signed [8:0] stepExt;
  logic signed [8:0] sum;
  logic signed [8:0] diff;

  assign posExt  = $signed({3'b000, pos_q});
  assign stepExt = $signed({6'b000000, step});
  assign sum     = posExt + stepExt;
  assign diff    = posExt - stepExt;

  // 9-bit signed working range keeps over- and underflow visible for clamping
  always_comb begin
    pos_d = pos_q;
    if (load) begin
      pos_d = load_value;
    end else if (plus && !minus) begin
      pos_d = (sum > MAX_S) ? pos_t'(MAX_POS) : sum[5:0];
    end else if (minus && !plus) begin
      pos_d = diff[8] ? '0 : diff[5:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pos_q <= CENTER_P;
    else        pos_q <= pos_d;
  end

  assign pos = pos_q;

endmodule

// File: rtl/gun_position.sv
// Light-gun position generator: once per frame moves the gun either to an
// absolute analog position or by a ramping digital speed, with recenter override.
module gun_position
  import gun_pkg::*;
#(
  parameter int MAX_POS     = 63,
  parameter int RAMP_FRAMES = 8,
  parameter int CENTER      = 32
) (
  input logic  clock_12,
  input logic  reset_n,
  gun_if.slave bus
);

  localparam int CNT_W = $clog2(RAMP_FRAMES + 1);

  logic             vblank_q;
  logic             tick;
  logic             frame_tick_q;
  speed_e           state_q, state_d, cur;
  logic [CNT_W-1:0] cnt_q, cnt_d, curCnt;
  logic [2:0]       step;
  logic             moveEn;
  logic             load;
  pos_t             loadH, loadV;
  pos_t             posH, posV;

  assign tick = bus.video_vblank & ~vblank_q;

  // IDLE with a direction held behaves as the first held frame of S1
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur     = state_q;
    curCnt  = cnt_q;
    step    = 3'd0;
    moveEn  = 1'b0;
    load    = 1'b0;
    loadH   = pos_t'(CENTER);
    loadV   = pos_t'(CENTER);
    if (tick) begin
      if (bus.recenter) begin
        load    = 1'b1;
        state_d = SPD_IDLE;
        cnt_d   = '0;
      end else if (bus.analog_mode) begin
        load    = 1'b1;
        loadH   = analogToPos(bus.joy_ax, MAX_POS);
        loadV   = analogToPos(bus.joy_ay, MAX_POS);
        state_d = SPD_IDLE;
        cnt_d   = '0;
      end else if (bus.joy_dir == 4'b0000) begin
        state_d = SPD_IDLE;
        cnt_d   = '0;
      end else begin
        if (state_q == SPD_IDLE) begin
          cur    = SPD_S1;
          curCnt = '0;
        end
        step   = cur;
        moveEn = 1'b1;
        if (cur != SPD_S4 && int'(curCnt) + 1 >= RAMP_FRAMES) begin
          state_d = speedNext(cur);
          cnt_d   = '0;
        end else begin
          state_d = cur;
          cnt_d   = (int'(curCnt) >= RAMP_FRAMES) ? curCnt : curCnt + CNT_W'(1);
        end
      end
    end
  end

  // vblank_q resets high so a vblank already high at reset release is not a tick
  always_ff @(posedge clock_12 or negedge reset_n) begin
    if (!reset_n) begin
      vblank_q     <= 1'b1;
      frame_tick_q <= 1'b0;
      state_q      <= SPD_IDLE;
      cnt_q        <= '0;
    end else begin
      vblank_q     <= bus.video_vblank;
      frame_tick_q <= tick;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
    end
  end

  gun_axis #(.MAX_POS(MAX_POS), .CENTER(CENTER)) uAxisH (
    .clk        (clock_12),
    .rst_n      (reset_n),
    .step       (step),
    .plus       (moveEn & bus.joy_dir[DIR_RIGHT]),
    .minus      (moveEn & bus.joy_dir[DIR_LEFT]),
    .load       (load),
    .load_value (loadH),
    .pos        (posH)
  );

  gun_axis #(.MAX_POS(MAX_POS), .CENTER(CENTER)) uAxisV (
    .clk        (clock_12),
    .rst_n      (reset_n),
    .step       (step),
    .plus       (moveEn & bus.joy_dir[DIR_DOWN]),
    .minus      (moveEn & bus.joy_dir[DIR_UP]),
    .load       (load),
    .load_value (loadV),
    .pos        (posV)
  );

  assign bus.gun_h      = posH;
  assign bus.gun_v      = posV;
  assign bus.frame_tick = frame_tick_q;

endmodule
